mem_master: RTL and testbench

MEM_MASTER -- requirements
Module: mem_master

---
 rtl/mem_master.sv | 139 +++++++++++++
 tb/tb_mem_master.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_master.sv
// Burst memory master: accepts fill-write or read bursts and drives a
// byte-wide synchronous-write / combinational-read memory port.
module mem_master #(
  parameter int unsigned MEM_DEPTH = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_len,
  input  logic [7:0] req_wdata,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [7:0] rd_data,
  output logic       rd_last,
  output logic       done,
  output logic       err,
  output logic       mem_read_enable,
  output logic       mem_write_enable,
  output logic [7:0] mem_address,
  output logic [7:0] mem_data,
  input  logic [7:0] mem_out
);

  localparam int unsigned AW = 8;
  localparam int unsigned SW = 9;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RHOLD} state_t;

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] addr;
  logic [AW-1:0] remaining;
  logic [AW-1:0] wdata;
  logic [SW-1:0] end_addr_c;
  logic          accept_c;
  logic          bad_req_c;
  logic          last_c;

  // Range check is done one bit wider so a burst cannot wrap past 0xFF.
  assign end_addr_c = SW'(req_addr) + SW'(req_len);
  assign bad_req_c  = (req_len == '0) || (end_addr_c > SW'(MEM_DEPTH));
  assign accept_c   = req_valid && (state == IDLE);
  assign last_c     = (remaining == AW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept_c && !bad_req_c) state_next = req_write ? WRITE : READ;
      WRITE: if (last_c) state_next = IDLE;
      READ:  state_next = RHOLD;
      RHOLD: if (rd_ready) state_next = last_c ? IDLE : READ;
      default: state_next = IDLE;
    endcase
  end

  // Memory strobes and handshake decoded from registered state only
  always_comb begin
    req_ready        = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_data         = '0;
    case (state)
      IDLE:  req_ready = 1'b1;
      WRITE: begin
        mem_write_enable = 1'b1;
        mem_address      = addr;
        mem_data         = wdata;
      end
      READ: begin
        mem_read_enable = 1'b1;
        mem_address     = addr;
      end
      RHOLD: mem_address = addr;
      default: req_ready = 1'b0;
    endcase
  end

  // Burst counters, read-data register and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= '0;
      remaining <= '0;
      wdata     <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_last   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c) begin
            addr      <= req_addr;
            remaining <= req_len;
            wdata     <= req_wdata;
            err       <= bad_req_c;
          end
        end
        WRITE: begin
          addr      <= addr + AW'(1);
          remaining <= remaining - AW'(1);
          done      <= last_c;
        end
        READ: begin
          rd_data  <= mem_out;
          rd_valid <= 1'b1;
          rd_last  <= last_c;
        end
        RHOLD: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (last_c) begin
              done <= 1'b1;
            end else begin
              addr      <= addr + AW'(1);
              remaining <= remaining - AW'(1);
            end
          end
        end
        default: done <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Directed self-checking bench for mem_master with a byte memory model
// whose unwritten locations read back (addr+1)*0x11.
module tb_mem_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_len;
  logic [7:0] req_wdata;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_last;
  logic       done;
  logic       err;
  logic       mem_read_enable;
  logic       mem_write_enable;
  logic [7:0] mem_address;
  logic [7:0] mem_data;
  logic [7:0] mem_out;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int wr0;
  int rd0;

  logic [7:0]   wmem [0:255];
  logic [255:0] wvalid = '0;

  mem_master #(.MEM_DEPTH(9)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .err(err),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_data(mem_data), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  assign mem_out = wvalid[mem_address] ? wmem[mem_address]
                                       : 8'((32'(mem_address) + 1) * 17);

  always @(posedge clk) begin
    if (mem_write_enable) begin
      wmem[mem_address]   <= mem_data;
      wvalid[mem_address] <= 1'b1;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_read_enable) rd_cnt <= rd_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] l,
                       input logic [7:0] d);
    req_valid = 1'b1; req_write = w; req_addr = a; req_len = l; req_wdata = d;
    tick();
    req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_len = 8'h00; req_wdata = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    req_wdata = '0; rd_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({req_ready, rd_valid, rd_data, rd_last, done, err} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_status: got rdy=%b rv=%b rd=%h rl=%b done=%b err=%b, need 1 0 00 0 0 0",
               req_ready, rd_valid, rd_data, rd_last, done, err);
    end
    checks++;
    if ({mem_read_enable, mem_write_enable, mem_address, mem_data} !== 18'h0) begin
      errors++;
      $display("FAIL reset_mem: got re=%b we=%b a=%h d=%h, need all 0",
               mem_read_enable, mem_write_enable, mem_address, mem_data);
    end
  endtask

  task automatic test_write();
    wr0 = wr_cnt;
    issue(1'b1, 8'h02, 8'd3, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({mem_write_enable, mem_read_enable, mem_address, mem_data, req_ready, done} !==
          {1'b1, 1'b0, 8'(8'h02 + i), 8'hA5, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL write_beat%0d: got we=%b re=%b a=%h d=%h rdy=%b done=%b, need 1 0 %h a5 0 0",
                 i, mem_write_enable, mem_read_enable, mem_address, mem_data, req_ready, done,
                 8'(8'h02 + i));
      end
      tick();
    end
    checks++;
    if ({done, req_ready, mem_write_enable, mem_address, mem_data} !== {1'b1, 1'b1, 1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL write_done: got done=%b rdy=%b we=%b a=%h d=%h, need 1 1 0 00 00",
               done, req_ready, mem_write_enable, mem_address, mem_data);
    end
    tick();
    checks++;
    if ({done, wr_cnt - wr0, wmem[2], wmem[3], wmem[4]} !== {1'b0, 32'd3, 8'hA5, 8'hA5, 8'hA5}) begin
      errors++;
      $display("FAIL write_after: got done=%b strobes=%0d mem=%h %h %h, need 0 3 a5 a5 a5",
               done, wr_cnt - wr0, wmem[2], wmem[3], wmem[4]);
    end
  endtask

  task automatic test_read();
    rd0 = rd_cnt;
    rd_ready = 1'b1;
    issue(1'b0, 8'h00, 8'd2, 8'h00);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({mem_read_enable, mem_write_enable, mem_address, rd_valid} !== {1'b1, 1'b0, 8'(i), 1'b0}) begin
        errors++;
        $display("FAIL read_strobe%0d: got re=%b we=%b a=%h rv=%b, need 1 0 %h 0",
                 i, mem_read_enable, mem_write_enable, mem_address, rd_valid, 8'(i));
      end
      tick();
      checks++;
      if ({rd_valid, rd_data, rd_last, mem_read_enable, done} !==
          {1'b1, (i == 0) ? 8'h11 : 8'h22, (i == 1), 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL read_byte%0d: got rv=%b rd=%h rl=%b re=%b done=%b, need 1 %h %b 0 0",
                 i, rd_valid, rd_data, rd_last, mem_read_enable, done,
                 (i == 0) ? 8'h11 : 8'h22, (i == 1));
      end
      tick();
    end
    checks++;
    if ({done, rd_valid, rd_last, req_ready, rd_cnt - rd0} !== {1'b1, 1'b0, 1'b0, 1'b1, 32'd2}) begin
      errors++;
      $display("FAIL read_done: got done=%b rv=%b rl=%b rdy=%b strobes=%0d, need 1 0 0 1 2",
               done, rd_valid, rd_last, req_ready, rd_cnt - rd0);
    end
    tick();
  endtask

  task automatic test_stall();
    rd0 = rd_cnt;
    rd_ready = 1'b0;
    issue(1'b0, 8'h05, 8'd2, 8'h00);
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rd_valid, rd_data, rd_last, mem_address, mem_read_enable} !==
          {1'b1, 8'h66, 1'b0, 8'h05, 1'b0}) begin
        errors++;
        $display("FAIL stall%0d: got rv=%b rd=%h rl=%b a=%h re=%b, need 1 66 0 05 0",
                 i, rd_valid, rd_data, rd_last, mem_address, mem_read_enable);
      end
      tick();
    end
    rd_ready = 1'b1;
    tick();
    checks++;
    if ({mem_read_enable, mem_address, rd_valid} !== {1'b1, 8'h06, 1'b0}) begin
      errors++;
      $display("FAIL stall_next: got re=%b a=%h rv=%b, need 1 06 0",
               mem_read_enable, mem_address, rd_valid);
    end
    tick();
    checks++;
    if ({rd_valid, rd_data, rd_last} !== {1'b1, 8'h77, 1'b1}) begin
      errors++;
      $display("FAIL stall_last: got rv=%b rd=%h rl=%b, need 1 77 1", rd_valid, rd_data, rd_last);
    end
    tick();
    checks++;
    if ({done, rd_valid, rd_cnt - rd0} !== {1'b1, 1'b0, 32'd2}) begin
      errors++;
      $display("FAIL stall_done: got done=%b rv=%b strobes=%0d, need 1 0 2",
               done, rd_valid, rd_cnt - rd0);
    end
    tick();
  endtask

  task automatic test_range();
    logic [7:0] bad_addr [2];
    logic [7:0] bad_len  [2];
    bad_addr[0] = 8'h07; bad_len[0] = 8'd3;
    bad_addr[1] = 8'h00; bad_len[1] = 8'd0;
    for (int i = 0; i < 2; i++) begin
      wr0 = wr_cnt; rd0 = rd_cnt;
      issue(1'b0, bad_addr[i], bad_len[i], 8'h00);
      checks++;
      if ({err, req_ready, mem_read_enable, mem_write_enable} !== 4'b1100) begin
        errors++;
        $display("FAIL range_err%0d: got err=%b rdy=%b re=%b we=%b, need 1 1 0 0",
                 i, err, req_ready, mem_read_enable, mem_write_enable);
      end
      tick(); tick();
      checks++;
      if ({err, done, wr_cnt - wr0 + rd_cnt - rd0} !== {1'b0, 1'b0, 32'd0}) begin
        errors++;
        $display("FAIL range_quiet%0d: got err=%b done=%b strobes=%0d, need 0 0 0",
                 i, err, done, wr_cnt - wr0 + rd_cnt - rd0);
      end
    end
    wr0 = wr_cnt;
    issue(1'b1, 8'h08, 8'd1, 8'h5A);
    checks++;
    if ({err, mem_write_enable, mem_address, mem_data} !== {1'b0, 1'b1, 8'h08, 8'h5A}) begin
      errors++;
      $display("FAIL range_edge: got err=%b we=%b a=%h d=%h, need 0 1 08 5a",
               err, mem_write_enable, mem_address, mem_data);
    end
    tick();
    checks++;
    if ({done, wr_cnt - wr0} !== {1'b1, 32'd1}) begin
      errors++;
      $display("FAIL range_edge_done: got done=%b strobes=%0d, need 1 1", done, wr_cnt - wr0);
    end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    logic seen_done;
    seen_done = 1'b0;
    issue(1'b1, 8'h00, 8'd4, 8'h3C);
    tick();
    checks++;
    if ({mem_write_enable, mem_address} !== {1'b1, 8'h01}) begin
      errors++;
      $display("FAIL abort_byte2: got we=%b a=%h, need 1 01", mem_write_enable, mem_address);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({mem_write_enable, mem_read_enable, mem_address, mem_data, req_ready, done, err} !==
        {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_state: got we=%b re=%b a=%h d=%h rdy=%b done=%b err=%b, need 0 0 00 00 1 0 0",
               mem_write_enable, mem_read_enable, mem_address, mem_data, req_ready, done, err);
    end
    for (int i = 0; i < 3; i++) begin
      if (done) seen_done = 1'b1;
      tick();
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got done pulse=%b, need 0", seen_done);
    end
    wr0 = wr_cnt;
    issue(1'b1, 8'h06, 8'd1, 8'h77);
    checks++;
    if ({mem_write_enable, mem_address, mem_data} !== {1'b1, 8'h06, 8'h77}) begin
      errors++;
      $display("FAIL abort_recover: got we=%b a=%h d=%h, need 1 06 77",
               mem_write_enable, mem_address, mem_data);
    end
    tick();
    checks++;
    if ({done, wr_cnt - wr0, wmem[6]} !== {1'b1, 32'd1, 8'h77}) begin
      errors++;
      $display("FAIL abort_recover_done: got done=%b strobes=%0d mem6=%h, need 1 1 77",
               done, wr_cnt - wr0, wmem[6]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    rd_ready = 1'b1;
    issue(1'b1, 8'h00, 8'd1, 8'h99);
    // Offer the read while still in WRITE; it must wait for the done cycle.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h00; req_len = 8'd1;
    tick();
    checks++;
    if ({done, req_ready, mem_write_enable, mem_read_enable} !== 4'b1100) begin
      errors++;
      $display("FAIL b2b_done: got done=%b rdy=%b we=%b re=%b, need 1 1 0 0",
               done, req_ready, mem_write_enable, mem_read_enable);
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if ({mem_read_enable, mem_address, done} !== {1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL b2b_read: got re=%b a=%h done=%b, need 1 00 0",
               mem_read_enable, mem_address, done);
    end
    tick();
    checks++;
    if ({rd_valid, rd_data, rd_last} !== {1'b1, 8'h99, 1'b1}) begin
      errors++;
      $display("FAIL b2b_data: got rv=%b rd=%h rl=%b, need 1 99 1", rd_valid, rd_data, rd_last);
    end
    tick();
    checks++;
    if ({done, rd_valid, req_ready} !== 3'b101) begin
      errors++;
      $display("FAIL b2b_end: got done=%b rv=%b rdy=%b, need 1 0 1", done, rd_valid, req_ready);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_stall();
    test_range();
    test_reset_mid_burst();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
